// File: rtl/id_stage_pipe_if.sv
// Bundle of handshake, operand, writeback and branch-redirect signals for the ID stage.
// The slave modport is the stage itself; the master modport is whatever drives it.
interface id_stage_pipe_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5,
  parameter int LANE_W = 8,
  parameter int PC_W   = 16
) ();
  localparam int LANES = DATA_W / LANE_W;

  // Decode-side handshake and decoded instruction fields
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] in_rA;
  logic [ADDR_W-1:0] in_rB;
  logic [ADDR_W-1:0] in_rD;
  logic              in_useA;
  logic              in_useB;
  logic              in_wrEn;
  logic              in_memEn;
  logic              in_memwrEn;
  logic [1:0]        in_br_type;
  logic [PC_W-1:0]   in_br_pc;

  // Writeback port into the register file
  logic              wb_wrEn;
  logic [ADDR_W-1:0] wb_rD;
  logic [LANES-1:0]  wb_lane_en;
  logic [DATA_W-1:0] wb_data;

  // ID/EX register toward the execute stage
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_rA_data;
  logic [DATA_W-1:0] out_rB_data;
  logic [ADDR_W-1:0] out_rD;
  logic              out_wrEn;
  logic              out_memEn;
  logic              out_memwrEn;
  logic              out_fwd_rA;
  logic              out_fwd_rB;

  // Branch redirect and performance counter
  logic              br_taken;
  logic [PC_W-1:0]   br_pc;
  logic [15:0]       perf_stalls;

  modport master (
    output in_valid, in_rA, in_rB, in_rD, in_useA, in_useB,
           in_wrEn, in_memEn, in_memwrEn, in_br_type, in_br_pc,
           wb_wrEn, wb_rD, wb_lane_en, wb_data, out_ready,
    input  in_ready, out_valid, out_rA_data, out_rB_data, out_rD,
           out_wrEn, out_memEn, out_memwrEn, out_fwd_rA, out_fwd_rB,
           br_taken, br_pc, perf_stalls
  );

  modport slave (
    input  in_valid, in_rA, in_rB, in_rD, in_useA, in_useB,
           in_wrEn, in_memEn, in_memwrEn, in_br_type, in_br_pc,
           wb_wrEn, wb_rD, wb_lane_en, wb_data, out_ready,
    output in_ready, out_valid, out_rA_data, out_rB_data, out_rD,
           out_wrEn, out_memEn, out_memwrEn, out_fwd_rA, out_fwd_rB,
           br_taken, br_pc, perf_stalls
  );
endinterface

// File: rtl/id_stage_pipe.sv
// Instruction-decode pipeline stage: lane-writable register file with write-through
// bypass, load-use hazard stall, ID/EX register with EX-forward flags, bez/bnez
// resolution with a one-instruction shadow flush, and a saturating stall counter.
module id_stage_pipe #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5,
  parameter int LANE_W = 8,
  parameter int PC_W   = 16
) (
  input logic          clk,
  input logic          reset,
  id_stage_pipe_if.slave bus
);
  localparam int LANES = DATA_W / LANE_W;
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {
    FLUSH_IDLE,
    FLUSH_ARMED
  } flush_state_t;

  logic [DATA_W-1:0] rf [DEPTH];
  logic [DATA_W-1:0] wb_mask;
  logic [DATA_W-1:0] rd_a;
  logic [DATA_W-1:0] rd_b;

  logic              hazard;
  logic              ready;
  logic              accept;
  logic              drop;
  logic              br_cond;
  logic              br_fire;
  logic              fwd_a;
  logic              fwd_b;

  flush_state_t      flush_q;
  flush_state_t      flush_d;

  logic              out_valid_q;
  logic [DATA_W-1:0] out_a_q;
  logic [DATA_W-1:0] out_b_q;
  logic [ADDR_W-1:0] out_rd_q;
  logic              out_wr_q;
  logic              out_mem_q;
  logic              out_memwr_q;
  logic              out_fwd_a_q;
  logic              out_fwd_b_q;
  logic              br_taken_q;
  logic [PC_W-1:0]   br_pc_q;
  logic [15:0]       perf_q;

  // Expand the per-lane writeback enables into a full-width bit mask
  always_comb begin
    wb_mask = '0;
    for (int i = 0; i < LANES; i++) begin
      wb_mask[i*LANE_W +: LANE_W] = {LANE_W{bus.wb_lane_en[i]}};
    end
  end

  // Register file: per-lane writes, cleared by reset, entry 0 is an ordinary register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int e = 0; e < DEPTH; e++) begin
        rf[e] <= '0;
      end
    end else if (bus.wb_wrEn) begin
      for (int i = 0; i < LANES; i++) begin
        if (bus.wb_lane_en[i]) begin
          rf[bus.wb_rD][i*LANE_W +: LANE_W] <= bus.wb_data[i*LANE_W +: LANE_W];
        end
      end
    end
  end

  // Combinational reads; a same-cycle writeback to the read index shows through lane by lane
  always_comb begin
    rd_a = rf[bus.in_rA];
    rd_b = rf[bus.in_rB];
    if (bus.wb_wrEn && (bus.wb_rD == bus.in_rA)) begin
      rd_a = (rd_a & ~wb_mask) | (bus.wb_data & wb_mask);
    end
    if (bus.wb_wrEn && (bus.wb_rD == bus.in_rB)) begin
      rd_b = (rd_b & ~wb_mask) | (bus.wb_data & wb_mask);
    end
  end

  // A load sitting in ID/EX cannot forward its data yet, so a dependent reader must wait
  assign hazard = bus.in_valid & out_valid_q & out_wr_q & out_mem_q &
                  ((bus.in_useA & (bus.in_rA == out_rd_q)) |
                   (bus.in_useB & (bus.in_rB == out_rd_q)));

  assign ready  = ~hazard & (~out_valid_q | bus.out_ready);
  assign accept = bus.in_valid & ready;
  assign drop   = accept & (flush_q == FLUSH_ARMED);

  // Non-load results in ID/EX can be forwarded by EX, so flag the matching sources
  assign fwd_a = out_valid_q & out_wr_q & ~out_mem_q & bus.in_useA & (bus.in_rA == out_rd_q);
  assign fwd_b = out_valid_q & out_wr_q & ~out_mem_q & bus.in_useB & (bus.in_rB == out_rD_alias());

  function automatic logic [ADDR_W-1:0] out_rD_alias();
    return out_rd_q;
  endfunction

  // Branch condition from the bypassed rB operand; the reserved encoding never branches
  always_comb begin
    br_cond = 1'b0;
    case (bus.in_br_type)
      2'b01:   br_cond = (rd_b == '0);
      2'b10:   br_cond = (rd_b != '0);
      default: br_cond = 1'b0;
    endcase
  end

  assign br_fire = accept & ~drop & br_cond;

  // Shadow-flush state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flush_q <= FLUSH_IDLE;
    end else begin
      flush_q <= flush_d;
    end
  end

  // Arm on a taken branch; the next accepted instruction is the one discarded
  always_comb begin
    flush_d = flush_q;
    case (flush_q)
      FLUSH_IDLE:  if (br_fire) flush_d = FLUSH_ARMED;
      FLUSH_ARMED: if (accept)  flush_d = FLUSH_IDLE;
      default:     flush_d = FLUSH_IDLE;
    endcase
  end

  // ID/EX register: load on a kept accept, bubble when drained, hold while EX stalls
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_a_q     <= '0;
      out_b_q     <= '0;
      out_rd_q    <= '0;
      out_wr_q    <= 1'b0;
      out_mem_q   <= 1'b0;
      out_memwr_q <= 1'b0;
      out_fwd_a_q <= 1'b0;
      out_fwd_b_q <= 1'b0;
    end else if (accept && !drop) begin
      out_valid_q <= 1'b1;
      out_a_q     <= rd_a;
      out_b_q     <= rd_b;
      out_rd_q    <= bus.in_rD;
      out_wr_q    <= bus.in_wrEn;
      out_mem_q   <= bus.in_memEn;
      out_memwr_q <= bus.in_memwrEn;
      out_fwd_a_q <= fwd_a;
      out_fwd_b_q <= fwd_b;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  // One-cycle redirect pulse; the target is only updated when a branch actually fires
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      br_taken_q <= 1'b0;
      br_pc_q    <= '0;
    end else begin
      br_taken_q <= br_fire;
      if (br_fire) begin
        br_pc_q <= bus.in_br_pc;
      end
    end
  end

  // Count hazard-stall cycles, sticking at all-ones instead of wrapping
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_q <= '0;
    end else if (hazard && (perf_q != 16'hFFFF)) begin
      perf_q <= perf_q + 16'd1;
    end
  end

  assign bus.in_ready    = ready;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_rA_data = out_a_q;
  assign bus.out_rB_data = out_b_q;
  assign bus.out_rD      = out_rd_q;
  assign bus.out_wrEn    = out_wr_q;
  assign bus.out_memEn   = out_mem_q;
  assign bus.out_memwrEn = out_memwr_q;
  assign bus.out_fwd_rA  = out_fwd_a_q;
  assign bus.out_fwd_rB  = out_fwd_b_q;
  assign bus.br_taken    = br_taken_q;
  assign bus.br_pc       = br_pc_q;
  assign bus.perf_stalls = perf_q;
endmodule

// File: tb/tb_id_stage_pipe.sv
// Testbench for id_stage_pipe: directed scenarios plus randomized traffic, checked
// against a behavioural model; a scoreboard queue feeds a negedge monitor.
module tb_id_stage_pipe;
  localparam int DATA_W = 64;
  localparam int ADDR_W = 5;
  localparam int LANE_W = 8;
  localparam int PC_W   = 16;

  typedef struct packed {
    logic        in_valid;
    logic [4:0]  rA;
    logic [4:0]  rB;
    logic [4:0]  rD;
    logic        useA;
    logic        useB;
    logic        wrEn;
    logic        memEn;
    logic        memwrEn;
    logic [1:0]  br_type;
    logic [15:0] br_pc;
    logic        wb_wrEn;
    logic [4:0]  wb_rD;
    logic [7:0]  wb_lane_en;
    logic [63:0] wb_data;
    logic        out_ready;
  } stim_t;

  typedef struct packed {
    logic [63:0] a;
    logic [63:0] b;
    logic [4:0]  rd;
    logic        wr;
    logic        mem;
    logic        memwr;
    logic        fwd_a;
    logic        fwd_b;
  } out_txn_t;

  typedef struct packed {
    logic [15:0] pc;
    logic [31:0] cyc;
  } br_txn_t;

  logic clk = 1'b0;
  logic reset;

  id_stage_pipe_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LANE_W(LANE_W), .PC_W(PC_W)) bus ();

  id_stage_pipe #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LANE_W(LANE_W), .PC_W(PC_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;
  logic [31:0] cyc = '0;

  out_txn_t out_q[$];
  br_txn_t  br_q[$];

  // Reference model state: register contents, what sits in ID/EX, flush and stall count
  logic [63:0] m_rf [32];
  logic        m_out_valid;
  logic [4:0]  m_out_rd;
  logic        m_out_wr;
  logic        m_out_mem;
  logic        m_flush;
  int          m_stalls;

  task automatic check_output(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] lane_mask(input logic [7:0] en);
    logic [63:0] m;
    m = '0;
    for (int i = 0; i < 8; i++) begin
      if (en[i]) m[i*8 +: 8] = 8'hFF;
    end
    return m;
  endfunction

  function automatic logic [63:0] m_read(input logic [4:0] idx, input stim_t s);
    logic [63:0] mask;
    mask = lane_mask(s.wb_lane_en);
    if (s.wb_wrEn && (s.wb_rD == idx)) return (m_rf[idx] & ~mask) | (s.wb_data & mask);
    return m_rf[idx];
  endfunction

  function automatic stim_t idle_stim();
    stim_t s;
    s = '0;
    s.out_ready = 1'b1;
    return s;
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    s.in_valid   = ($urandom_range(0, 9) < 8);
    s.rA         = 5'($urandom_range(0, 3));
    s.rB         = 5'($urandom_range(0, 3));
    s.rD         = 5'($urandom_range(0, 3));
    s.useA       = 1'($urandom_range(0, 1));
    s.useB       = 1'($urandom_range(0, 1));
    s.wrEn       = 1'($urandom_range(0, 1));
    s.memEn      = ($urandom_range(0, 2) == 0);
    s.memwrEn    = 1'($urandom_range(0, 1));
    s.br_type    = 2'($urandom_range(0, 3));
    s.br_pc      = 16'($urandom);
    s.wb_wrEn    = 1'($urandom_range(0, 1));
    s.wb_rD      = 5'($urandom_range(0, 3));
    s.wb_lane_en = 8'($urandom);
    s.wb_data    = ($urandom_range(0, 2) == 0) ? 64'h0 : {32'($urandom), 32'($urandom)};
    s.out_ready  = ($urandom_range(0, 3) != 0);
    return s;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_rf[i] = '0;
    m_out_valid = 1'b0;
    m_out_rd    = '0;
    m_out_wr    = 1'b0;
    m_out_mem   = 1'b0;
    m_flush     = 1'b0;
    m_stalls    = 0;
    out_q.delete();
    br_q.delete();
  endtask

  task automatic drive(input stim_t s);
    bus.in_valid   = s.in_valid;
    bus.in_rA      = s.rA;
    bus.in_rB      = s.rB;
    bus.in_rD      = s.rD;
    bus.in_useA    = s.useA;
    bus.in_useB    = s.useB;
    bus.in_wrEn    = s.wrEn;
    bus.in_memEn   = s.memEn;
    bus.in_memwrEn = s.memwrEn;
    bus.in_br_type = s.br_type;
    bus.in_br_pc   = s.br_pc;
    bus.wb_wrEn    = s.wb_wrEn;
    bus.wb_rD      = s.wb_rD;
    bus.wb_lane_en = s.wb_lane_en;
    bus.wb_data    = s.wb_data;
    bus.out_ready  = s.out_ready;
  endtask

  // One clock of stimulus: drive after the edge, check handshake/state, then advance the model
  task automatic apply_stimulus(input stim_t s);
    logic hazard, ready, accept, taken;
    logic [63:0] a, b, mask;
    out_txn_t t;
    br_txn_t bt;
    @(posedge clk);
    #1;
    cyc++;
    drive(s);
    #1;
    hazard = s.in_valid && m_out_valid && m_out_wr && m_out_mem &&
             ((s.useA && s.rA == m_out_rd) || (s.useB && s.rB == m_out_rd));
    ready  = !hazard && (!m_out_valid || s.out_ready);
    check_output("in_ready", 256'(bus.in_ready), 256'(ready));
    check_output("out_valid", 256'(bus.out_valid), 256'(m_out_valid));
    check_output("perf_stalls", 256'(bus.perf_stalls), 256'(m_stalls));
    accept = s.in_valid && ready;
    a = m_read(s.rA, s);
    b = m_read(s.rB, s);
    if (accept && m_flush) begin
      m_flush     = 1'b0;
      m_out_valid = 1'b0;
    end else if (accept) begin
      taken   = (s.br_type == 2'b01 && b == 64'h0) || (s.br_type == 2'b10 && b != 64'h0);
      t.a     = a;
      t.b     = b;
      t.rd    = s.rD;
      t.wr    = s.wrEn;
      t.mem   = s.memEn;
      t.memwr = s.memwrEn;
      t.fwd_a = m_out_valid && m_out_wr && !m_out_mem && s.useA && (s.rA == m_out_rd);
      t.fwd_b = m_out_valid && m_out_wr && !m_out_mem && s.useB && (s.rB == m_out_rd);
      out_q.push_back(t);
      if (taken) begin
        bt.pc  = s.br_pc;
        bt.cyc = cyc + 32'd1;
        br_q.push_back(bt);
        m_flush = 1'b1;
      end
      m_out_valid = 1'b1;
      m_out_rd    = s.rD;
      m_out_wr    = s.wrEn;
      m_out_mem   = s.memEn;
    end else if (s.out_ready) begin
      m_out_valid = 1'b0;
    end
    if (hazard && m_stalls < 65535) m_stalls++;
    if (s.wb_wrEn) begin
      mask = lane_mask(s.wb_lane_en);
      m_rf[s.wb_rD] = (m_rf[s.wb_rD] & ~mask) | (s.wb_data & mask);
    end
  endtask

  // Assert reset between edges, confirm everything cleared at once, release after two clocks
  task automatic do_reset();
    reset = 1'b1;
    drive(idle_stim());
    #1;
    check_output("reset_outputs",
      256'({bus.out_valid, bus.out_rA_data, bus.out_rB_data, bus.out_rD, bus.out_wrEn,
            bus.out_memEn, bus.out_memwrEn, bus.out_fwd_rA, bus.out_fwd_rB,
            bus.br_taken, bus.br_pc, bus.perf_stalls}), 256'(0));
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;
  endtask

  // Scoreboard monitor: pop on every consumed ID/EX entry and check redirect pulses
  always @(negedge clk) begin
    out_txn_t act;
    out_txn_t exp;
    if (bus.out_valid && bus.out_ready) begin
      act = {bus.out_rA_data, bus.out_rB_data, bus.out_rD, bus.out_wrEn, bus.out_memEn,
             bus.out_memwrEn, bus.out_fwd_rA, bus.out_fwd_rB};
      if (out_q.size() == 0) begin
        checks++;
        fails++;
        $display("[TB] FAIL out_unexpected: got %0h expected no transaction", act);
      end else begin
        exp = out_q.pop_front();
        check_output("out_txn", 256'(act), 256'(exp));
      end
    end
    if (br_q.size() > 0 && br_q[0].cyc <= cyc) begin
      check_output("br_taken", 256'(bus.br_taken), 256'(1));
      check_output("br_pc", 256'(bus.br_pc), 256'(br_q[0].pc));
      void'(br_q.pop_front());
    end else begin
      check_output("br_taken_idle", 256'(bus.br_taken), 256'(0));
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    stim_t s;
    model_reset();
    do_reset();

    // Partial-lane writeback then read: only low four lanes land
    s = idle_stim(); s.wb_wrEn = 1; s.wb_rD = 3; s.wb_lane_en = 8'h0F; s.wb_data = 64'h1122334455667788;
    apply_stimulus(s);
    s = idle_stim(); s.in_valid = 1; s.rA = 3; s.useA = 1; s.rD = 1;
    apply_stimulus(s);
    apply_stimulus(idle_stim());
    check_output("lane_write_valid", 256'(bus.out_valid), 256'(1));
    check_output("lane_write_data", 256'(bus.out_rA_data), 256'(64'h0000000055667788));

    // Writeback and read of r5 in the same cycle
    s = idle_stim(); s.in_valid = 1; s.rA = 5; s.useA = 1; s.rD = 6; s.wrEn = 1;
    s.wb_wrEn = 1; s.wb_rD = 5; s.wb_lane_en = 8'hFF; s.wb_data = 64'hA5;
    apply_stimulus(s);
    apply_stimulus(idle_stim());
    check_output("bypass_data", 256'(bus.out_rA_data), 256'(64'hA5));

    // Load-use stall on r7
    do_reset();
    s = idle_stim(); s.in_valid = 1; s.rD = 7; s.wrEn = 1; s.memEn = 1;
    apply_stimulus(s);
    s = idle_stim(); s.in_valid = 1; s.rA = 7; s.useA = 1; s.rD = 8; s.wrEn = 1;
    apply_stimulus(s);
    check_output("loaduse_stall_ready", 256'(bus.in_ready), 256'(0));
    apply_stimulus(s);
    check_output("loaduse_bubble", 256'(bus.out_valid), 256'(0));
    check_output("loaduse_stalls", 256'(bus.perf_stalls), 256'(1));
    check_output("loaduse_release", 256'(bus.in_ready), 256'(1));
    apply_stimulus(idle_stim());
    check_output("loaduse_accepted", 256'({bus.out_valid, bus.out_rD}), 256'({1'b1, 5'd8}));

    // Taken bnez: one-cycle redirect, shadow instruction dropped, next one passes
    do_reset();
    s = idle_stim(); s.wb_wrEn = 1; s.wb_rD = 1; s.wb_lane_en = 8'hFF; s.wb_data = 64'h1;
    apply_stimulus(s);
    s = idle_stim(); s.in_valid = 1; s.rB = 1; s.useB = 1; s.br_type = 2'b10; s.br_pc = 16'h0040;
    apply_stimulus(s);
    s = idle_stim(); s.in_valid = 1; s.rD = 9; s.wrEn = 1;
    apply_stimulus(s);
    check_output("bnez_taken", 256'(bus.br_taken), 256'(1));
    check_output("bnez_pc", 256'(bus.br_pc), 256'(16'h0040));
    s = idle_stim(); s.in_valid = 1; s.rD = 10; s.wrEn = 1;
    apply_stimulus(s);
    check_output("bnez_pulse_end", 256'(bus.br_taken), 256'(0));
    check_output("bnez_shadow_dropped", 256'(bus.out_valid), 256'(0));
    apply_stimulus(idle_stim());
    check_output("bnez_next_passes", 256'({bus.out_valid, bus.out_rD}), 256'({1'b1, 5'd10}));

    // Downstream stall for three cycles, then reset in the middle of it
    s = idle_stim(); s.wb_wrEn = 1; s.wb_rD = 2; s.wb_lane_en = 8'hFF; s.wb_data = 64'hDEADBEEFCAFEF00D;
    apply_stimulus(s);
    s = idle_stim(); s.in_valid = 1; s.rA = 2; s.useA = 1; s.rD = 4; s.wrEn = 1; s.out_ready = 0;
    apply_stimulus(s);
    for (int k = 0; k < 3; k++) begin
      s = idle_stim(); s.in_valid = 1; s.rA = 1; s.useA = 1; s.rD = 5; s.out_ready = 0;
      apply_stimulus(s);
      check_output("stall_ready", 256'(bus.in_ready), 256'(0));
      check_output("stall_hold", 256'({bus.out_valid, bus.out_rA_data, bus.out_rD}),
                   256'({1'b1, 64'hDEADBEEFCAFEF00D, 5'd4}));
    end
    do_reset();

    // Randomized traffic against the model
    for (int n = 0; n < 800; n++) begin
      apply_stimulus(rand_stim());
    end
    for (int n = 0; n < 4; n++) begin
      apply_stimulus(idle_stim());
    end
    @(negedge clk);
    #1;
    check_output("out_queue_drained", 256'(out_q.size()), 256'(0));
    check_output("br_queue_drained", 256'(br_q.size()), 256'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/id_stage_pipe.md
ID_STAGE_PIPE -- requirements
Module: id_stage_pipe

Interface
REQ-001 SHALL expose parameters (name, default, meaning), one per line:
 DATA_W, 64, register width in bits
 ADDR_W, 5, register index width; RF holds 2**ADDR_W entries
 LANE_W, 8, write-lane width; LANES = DATA_W/LANE_W
 PC_W, 16, branch target width
REQ-002 SHALL expose ports (name direction width meaning), clock and reset first:
 clk  in  1  single clock, rising edge
 reset  in  1  asynchronous, active-high
 in_valid  in  1  decoded instruction present
 in_ready  out  1  stage accepts instruction this cycle
 in_rA, in_rB, in_rD  in  ADDR_W  source/destination indices
 in_useA, in_useB  in  1  source operand actually read
 in_wrEn, in_memEn, in_memwrEn  in  1  decoded control
 in_br_type  in  2  00 none, 01 bez, 10 bnez, 11 reserved (treated as none)
 in_br_pc  in  PC_W  branch target
 wb_wrEn  in  1  writeback enable
 wb_rD  in  ADDR_W  writeback index
 wb_lane_en  in  LANES  per-lane write enable
 wb_data  in  DATA_W  writeback data
 out_valid  out  1  ID/EX register holds instruction
 out_ready  in  1  EX consumes out this cycle
 out_rA_data, out_rB_data  out  DATA_W  registered operands
 out_rD  out  ADDR_W; out_wrEn, out_memEn, out_memwrEn  out  1  registered control
 out_fwd_rA, out_fwd_rB  out  1  registered forward-from-EX flags
 br_taken  out  1  one-cycle redirect pulse
 br_pc  out  PC_W  redirect target, valid with br_taken
 perf_stalls  out  16  saturating hazard-stall counter

Function
REQ-003 RF SHALL write, on rising clk with wb_wrEn=1, each lane i of entry wb_rD for which wb_lane_en[i]=1; other lanes unchanged; all entries writable including 0.
REQ-004 RF reads SHALL be combinational with per-lane write-through bypass: if wb_wrEn and wb_rD equals a read index, enabled lanes return wb_data, others return stored value.
REQ-005 Load-use hazard SHALL be: in_valid & out_valid & out_wrEn & out_memEn & ((in_useA & in_rA==out_rD) | (in_useB & in_rB==out_rD)).
REQ-006 in_ready SHALL equal !hazard & (!out_valid | out_ready); accept = in_valid & in_ready.
REQ-007 On accept, ID/EX register SHALL capture bypassed operands and control on the next rising edge and set out_valid=1, unless the instruction is flushed (REQ-010).
REQ-008 With no accept and out_ready=1, out_valid SHALL clear (bubble); with out_ready=0 all out_* SHALL hold.
REQ-009 out_fwd_rA SHALL capture out_valid & out_wrEn & !out_memEn & in_useA & (in_rA==out_rD) at accept; out_fwd_rB likewise for rB.
REQ-010 Branch SHALL resolve on accept using bypassed rB data: bez taken if zero, bnez taken if nonzero; br_taken=1 and br_pc=in_br_pc registered, asserted exactly one cycle after accept; the instruction itself proceeds to out normally.
REQ-011 On taken branch, a flush flag SHALL set; the next accepted instruction SHALL be dropped (out_valid not set, no branch evaluated), then flag clears; no other instruction is dropped.
REQ-012 A branch blocked by hazard SHALL not resolve until accepted; br_taken SHALL never pulse for a non-accepted or flushed instruction.
REQ-013 perf_stalls SHALL increment by 1 each cycle hazard=1, saturating at 16'hFFFF.
REQ-014 Simultaneous WB write and accept reading the same index SHALL capture the new lane values.

Reset
REQ-015 reset=1 SHALL asynchronously clear all RF entries, out_valid, all out_* data and control, out_fwd_*, br_taken, br_pc, flush flag and perf_stalls to 0.
REQ-016 Reset mid-operation SHALL discard any pending flush and in-flight instruction; first cycle after deassertion in_ready=1 if out_ready irrelevant (out_valid=0).

Verification
REQ-017 Bench SHALL cover:
 - WB r3=64'h1122334455667788 lanes 8'h0F, prior 0 -> read r3 = 64'h0000000055667788.
 - Same-cycle WB r5=64'hA5 all lanes and accept reading r5 -> out_rA_data=64'hA5.
 - out holds load to r7, in reads r7 (useA=1) -> in_ready=0 one cycle, bubble out_valid=0, perf_stalls=1, then accept.
 - bnez with rB=1, target 16'h0040 -> br_taken=1, br_pc=16'h0040 one cycle; next accepted instruction dropped, following one passes.
 - out_ready=0 for 3 cycles with out_valid=1 -> out_* stable, in_ready=0; reset asserted mid-stall -> all outputs 0 immediately.
